// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the four byte-lane data RAMs (one address bus) between the CPU
//   MEM-stage port and the DMA/boot-loader port. By default the CPU has
//   priority. A starvation counter forces a periodic DMA slot, and a lock
//   mode gives DMA exclusive use of the RAM while a program is loaded.
//   CPU accesses tagged as I/O space bypass the RAM entirely.
//
// Ports
//   clk, clrn            system clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata CPU MEM-stage access
//   cpu_stall            freeze IF..MEM registers this cycle
//   io_sel               CPU access targets I/O space instead of RAM
//   dma_req/lock/we/addr/wdata  DMA access request and exclusive-lock request
//   dma_gnt              DMA access is performed this cycle
//   dma_rvalid, dma_rdata  registered DMA read return (one-cycle valid)
//   ram_we/addr/wdata    shared RAM port
//   ram_rdata            RAM read data, valid before the next rising edge
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CPU_PRI  | CPU owns RAM when it needs it, DMA uses idle cycles
// DMA_SLOT | one forced DMA cycle after STARVE_MAX denied requests
// LOCK     | DMA owns RAM exclusively, CPU RAM accesses are stalled

module dmem_arbiter #(
  parameter int         ADDR_W     = 14,
  parameter int         STARVE_MAX = 8,
  parameter logic [7:0] IO_TAG     = 8'hff
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              io_sel,
  input  logic              dma_req,
  input  logic              dma_lock,
  input  logic [3:0]        dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [31:0]       dma_rdata,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] CPU_PRI  = 2'd0;
  localparam logic [1:0] DMA_SLOT = 2'd1;
  localparam logic [1:0] LOCK     = 2'd2;

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);

  logic [1:0]       state;
  logic [1:0]       nextState;
  logic [CNT_W-1:0] starveCnt;
  logic [CNT_W-1:0] nextStarveCnt;
  logic             cpuRam;
  logic             cpuGrant;

  // Byte offset and the bits above the RAM window play no part in RAM access.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{cpu_addr[1:0], cpu_addr[23:ADDR_W+2]};

  assign cpuRam = cpu_req & (cpu_addr[31:24] != IO_TAG);
  assign io_sel = cpu_req & ~cpuRam;

  always_comb begin
    dma_gnt   = 1'b0;
    cpu_stall = 1'b0;
    cpuGrant  = 1'b0;
    case (state)
      DMA_SLOT: begin
        if (dma_req) begin
          dma_gnt   = 1'b1;
          cpu_stall = cpuRam;
        end else begin
          cpuGrant = cpuRam;
        end
      end
      LOCK: begin
        dma_gnt   = dma_req;
        cpu_stall = cpuRam;
      end
      default: begin
        if (cpuRam) begin
          cpuGrant = 1'b1;
        end else begin
          dma_gnt = dma_req;
        end
      end
    endcase
  end

  // The address/data mux falls back to the CPU side whenever DMA is not
  // actually granted; write enables come only from the granted owner, so a
  // stalled CPU store never reaches the RAM.
  always_comb begin
    ram_addr  = cpu_addr[ADDR_W+1:2];
    ram_wdata = cpu_wdata;
    ram_we    = 4'b0000;
    if (dma_gnt) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_we    = dma_we;
    end else if (cpuGrant) begin
      ram_we = cpu_we;
    end
  end

  // A lock request outranks a starvation expiry in the same cycle.
  always_comb begin
    nextState     = CPU_PRI;
    nextStarveCnt = '0;
    case (state)
      DMA_SLOT: nextState = dma_lock ? LOCK : CPU_PRI;
      LOCK:     nextState = dma_lock ? LOCK : CPU_PRI;
      default: begin
        if (dma_req && !dma_gnt) begin
          if (starveCnt == STARVE_LAST) begin
            nextState = DMA_SLOT;
          end else begin
            nextStarveCnt = starveCnt + CNT_W'(1);
          end
        end
        if (dma_lock) begin
          nextState = LOCK;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= CPU_PRI;
      starveCnt <= '0;
    end else begin
      state     <= nextState;
      starveCnt <= nextStarveCnt;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else if (dma_gnt && (dma_we == 4'b0000)) begin
      dma_rvalid <= 1'b1;
      dma_rdata  <= ram_rdata;
    end else begin
      dma_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              clrn;
  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_stall;
  logic              io_sel;
  logic              dma_req;
  logic              dma_lock;
  logic [3:0]        dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [31:0]       dma_rdata;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  int assertCnt = 0;
  int failCnt   = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(8), .IO_TAG(8'hff)) dut (
    .clk(clk), .clrn(clrn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .io_sel(io_sel),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; inputs change here, checks follow #1 later.
  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    clrn      = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 4'h0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    dma_req   = 1'b0;
    dma_lock  = 1'b0;
    dma_we    = 4'h0;
    dma_addr  = '0;
    dma_wdata = 32'h0;
    ram_rdata = 32'h0;
    #1;
    checkVal("rst_rvalid", 32'(dma_rvalid), 32'd0);
    checkVal("rst_rdata", dma_rdata, 32'h0);
    checkVal("rst_stall", 32'(cpu_stall), 32'd0);
    checkVal("rst_gnt", 32'(dma_gnt), 32'd0);
    #11 clrn = 1'b1;

    // CPU store in CPU_PRI
    nextCycle();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0010; cpu_we = 4'hf; cpu_wdata = 32'h1111_2222;
    #1;
    checkVal("t1_addr", 32'(ram_addr), 32'd4);
    checkVal("t1_we", 32'(ram_we), 32'hf);
    checkVal("t1_wdata", ram_wdata, 32'h1111_2222);
    checkVal("t1_stall", 32'(cpu_stall), 32'd0);
    checkVal("t1_gnt", 32'(dma_gnt), 32'd0);
    checkVal("t1_io", 32'(io_sel), 32'd0);

    // DMA read in an idle CPU cycle
    nextCycle();
    cpu_req = 1'b0; cpu_we = 4'h0;
    dma_req = 1'b1; dma_addr = 14'd7; dma_we = 4'h0; ram_rdata = 32'hDEAD_BEEF;
    #1;
    checkVal("t2_gnt", 32'(dma_gnt), 32'd1);
    checkVal("t2_addr", 32'(ram_addr), 32'd7);
    checkVal("t2_we", 32'(ram_we), 32'h0);
    nextCycle();
    dma_req = 1'b0; ram_rdata = 32'h0;
    #1;
    checkVal("t2_rvalid", 32'(dma_rvalid), 32'd1);
    checkVal("t2_rdata", dma_rdata, 32'hDEAD_BEEF);
    nextCycle();
    #1;
    checkVal("t2_rvalid_drop", 32'(dma_rvalid), 32'd0);
    checkVal("t2_rdata_hold", dma_rdata, 32'hDEAD_BEEF);

    // Starvation: 8 denied cycles, then a forced DMA write slot
    nextCycle();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0020; cpu_we = 4'h0;
    dma_req = 1'b1; dma_addr = 14'd3; dma_we = 4'b0011; dma_wdata = 32'hA5A5_5A5A;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkVal($sformatf("t3_deny_gnt%0d", i), 32'(dma_gnt), 32'd0);
      checkVal($sformatf("t3_deny_stall%0d", i), 32'(cpu_stall), 32'd0);
      checkVal($sformatf("t3_deny_addr%0d", i), 32'(ram_addr), 32'd8);
      nextCycle();
    end
    #1;
    checkVal("t3_slot_gnt", 32'(dma_gnt), 32'd1);
    checkVal("t3_slot_stall", 32'(cpu_stall), 32'd1);
    checkVal("t3_slot_addr", 32'(ram_addr), 32'd3);
    checkVal("t3_slot_we", 32'(ram_we), 32'b0011);
    checkVal("t3_slot_wdata", ram_wdata, 32'hA5A5_5A5A);
    nextCycle();
    #1;
    checkVal("t3_after_gnt", 32'(dma_gnt), 32'd0);
    checkVal("t3_after_stall", 32'(cpu_stall), 32'd0);
    checkVal("t3_after_addr", 32'(ram_addr), 32'd8);
    checkVal("t3_wr_no_rvalid", 32'(dma_rvalid), 32'd0);
    // Counter restarted at 0: seven more denials must not open a slot yet
    for (int i = 0; i < 7; i++) begin
      nextCycle();
      #1;
      checkVal($sformatf("t3_restart_gnt%0d", i), 32'(dma_gnt), 32'd0);
    end
    nextCycle();
    dma_req = 1'b0;

    // Lock for 5 sampled cycles with a CPU RAM store pending
    nextCycle();
    cpu_req = 1'b1; cpu_addr = 32'h0000_0040; cpu_we = 4'hf;
    dma_lock = 1'b1; dma_req = 1'b1; dma_addr = 14'd5; dma_we = 4'h0;
    #1;
    checkVal("t4_first_stall", 32'(cpu_stall), 32'd0);
    checkVal("t4_first_gnt", 32'(dma_gnt), 32'd0);
    checkVal("t4_first_addr", 32'(ram_addr), 32'd16);
    checkVal("t4_first_we", 32'(ram_we), 32'hf);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      if (i == 4) dma_lock = 1'b0;
      #1;
      checkVal($sformatf("t4_lock_stall%0d", i), 32'(cpu_stall), 32'd1);
      checkVal($sformatf("t4_lock_gnt%0d", i), 32'(dma_gnt), 32'd1);
      checkVal($sformatf("t4_lock_addr%0d", i), 32'(ram_addr), 32'd5);
      checkVal($sformatf("t4_lock_we%0d", i), 32'(ram_we), 32'h0);
    end
    nextCycle();
    #1;
    checkVal("t4_release_stall", 32'(cpu_stall), 32'd0);
    checkVal("t4_release_gnt", 32'(dma_gnt), 32'd0);
    checkVal("t4_release_addr", 32'(ram_addr), 32'd16);
    checkVal("t4_release_we", 32'(ram_we), 32'hf);

    // CPU I/O access leaves the RAM to DMA
    nextCycle();
    cpu_addr = 32'hFF00_0004; cpu_we = 4'hf;
    dma_req = 1'b1; dma_addr = 14'd9; dma_we = 4'b1010;
    #1;
    checkVal("t5_io", 32'(io_sel), 32'd1);
    checkVal("t5_gnt", 32'(dma_gnt), 32'd1);
    checkVal("t5_stall", 32'(cpu_stall), 32'd0);
    checkVal("t5_we", 32'(ram_we), 32'b1010);
    checkVal("t5_addr", 32'(ram_addr), 32'd9);

    // Reset during LOCK with a DMA read in flight
    nextCycle();
    cpu_req = 1'b0; cpu_we = 4'h0;
    dma_lock = 1'b1; dma_req = 1'b1; dma_addr = 14'd2; dma_we = 4'h0;
    ram_rdata = 32'h1234_5678;
    #1;
    checkVal("t6_pre_gnt", 32'(dma_gnt), 32'd1);
    nextCycle();
    ram_rdata = 32'hCAFE_F00D;
    cpu_req = 1'b1; cpu_addr = 32'h0000_0080;
    #1;
    checkVal("t6_lock_stall", 32'(cpu_stall), 32'd1);
    checkVal("t6_lock_rvalid", 32'(dma_rvalid), 32'd1);
    checkVal("t6_lock_rdata", dma_rdata, 32'h1234_5678);
    #1 clrn = 1'b0;
    #1;
    checkVal("t6_rst_rvalid", 32'(dma_rvalid), 32'd0);
    checkVal("t6_rst_rdata", dma_rdata, 32'h0);
    checkVal("t6_rst_stall", 32'(cpu_stall), 32'd0);
    checkVal("t6_rst_addr", 32'(ram_addr), 32'h20);
    nextCycle();
    clrn = 1'b1; dma_lock = 1'b0; dma_req = 1'b0;
    #1;
    checkVal("t6_post_stall", 32'(cpu_stall), 32'd0);
    nextCycle();
    #1;
    checkVal("t6_post2_stall", 32'(cpu_stall), 32'd0);
    checkVal("t6_post2_rvalid", 32'(dma_rvalid), 32'd0);
    checkVal("t6_post2_addr", 32'(ram_addr), 32'h20);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the four byte-lane data RAMs (one shared address bus, clocked on inverted clk) between the CPU MEM-stage port and a DMA/boot-loader port.
- CPU has priority by default. A starvation counter guarantees DMA periodic slots. A lock mode gives DMA exclusive ownership for program loading.
- Generates the pipeline stall, and routes CPU I/O-space accesses (addr[31:24]==8'hff) away from RAM.

Parameters:
ADDR_W, 14, RAM word-address width (byte address bits [ADDR_W+1:2])
STARVE_MAX, 8, consecutive denied DMA request cycles before a forced DMA slot (>=1)
IO_TAG, 8'hff, value of addr[31:24] that marks CPU I/O space

Ports:
clk  in  1  system clock, rising edge
clrn  in  1  asynchronous active-low reset
cpu_req  in  1  MEM stage performs load or store this cycle
cpu_we  in  4  CPU byte write enables, bit i drives ram_we[i]
cpu_addr  in  32  CPU byte address (ALU result)
cpu_wdata  in  32  CPU store data
cpu_stall  out  1  freeze IF..MEM registers this cycle
io_sel  out  1  CPU access targets I/O space (bypasses RAM)
dma_req  in  1  DMA access request, held until granted
dma_lock  in  1  request exclusive RAM ownership for DMA
dma_we  in  4  DMA byte write enables (all 0 = read)
dma_addr  in  ADDR_W  DMA word address
dma_wdata  in  32  DMA write data
dma_gnt  out  1  DMA access performed this cycle
dma_rvalid  out  1  dma_rdata valid (one cycle)
dma_rdata  out  32  registered DMA read data
ram_we  out  4  RAM byte-lane write enables
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid before next rising clk edge

Behaviour:
- Reset (clrn=0, async): state=CPU_PRI, starve_cnt=0, dma_rvalid=0, dma_rdata=0. All combinational outputs follow from CPU_PRI with registers cleared.
- cpu_ram = cpu_req & (cpu_addr[31:24]!=IO_TAG). io_sel = cpu_req & ~cpu_ram, in every state.
- Owner mux: when owner=CPU, ram_addr=cpu_addr[ADDR_W+1:2], ram_wdata=cpu_wdata, ram_we=cpu_we. When owner=DMA, the DMA fields drive RAM.
- When no access is granted, ram_we=0 and the address/data mux defaults to CPU.
- State CPU_PRI:
  - cpu_ram=1: CPU owns RAM, dma_gnt=0.
  - cpu_ram=0 and dma_req=1: DMA owns RAM, dma_gnt=1.
  - cpu_stall=0 in this state.
- Starvation counter (CPU_PRI only):
  - starve_cnt increments each cycle dma_req=1 & dma_gnt=0. It clears on any dma_gnt or when dma_req=0.
  - When the counter equals STARVE_MAX-1 while still denied, next state=DMA_SLOT.
- State DMA_SLOT (exactly one cycle):
  - dma_req=1: DMA owns RAM, dma_gnt=1, cpu_stall=cpu_ram.
  - dma_req=0: no grant, CPU served normally, cpu_stall=0.
  - starve_cnt cleared. Next state=CPU_PRI, or LOCK if dma_lock=1.
- Transition to LOCK: from CPU_PRI, next state=LOCK when dma_lock=1 is sampled. Lock takes effect the following cycle, so the sampling cycle is arbitrated normally.
- State LOCK:
  - DMA owns RAM. dma_gnt=dma_req. cpu_stall=cpu_ram.
  - CPU I/O accesses proceed unstalled.
  - Next state=CPU_PRI when dma_lock=0 is sampled. starve_cnt held at 0.
- dma_lock=1 and starvation expiry in the same cycle: LOCK wins, DMA_SLOT is skipped.
- DMA read return:
  - At the rising edge ending a cycle with dma_gnt=1 & dma_we=0: dma_rdata<=ram_rdata, dma_rvalid<=1.
  - Otherwise dma_rvalid<=0 and dma_rdata holds.
  - DMA writes never raise dma_rvalid.
- Stall contract: while cpu_stall=1 the CPU holds cpu_req/cpu_addr/cpu_we/cpu_wdata stable. The RAM sees ram_we only from the owner, so a stalled store is not written until it is the owner.
- CPU load data is unchanged: ram_rdata is valid in the CPU-owned cycle, and the arbiter adds no latency.
- Reset asserted mid-LOCK or mid-DMA_SLOT returns to CPU_PRI immediately. Any in-flight DMA read is lost (dma_rvalid=0).

Test Plan:
1. Reset, then cpu_req=1, cpu_addr=0x0000_0010, cpu_we=4'b1111, dma_req=0 -> ram_addr=4, ram_we=4'b1111, cpu_stall=0, dma_gnt=0.
2. cpu_req=0, dma_req=1, dma_addr=7, dma_we=0, ram_rdata=0xDEADBEEF -> dma_gnt=1 that cycle; next cycle dma_rvalid=1, dma_rdata=0xDEADBEEF, then dma_rvalid=0.
3. cpu_ram=1 continuously, dma_req=1 held, STARVE_MAX=8 -> dma_gnt=0 for 8 cycles; 9th cycle dma_gnt=1 with cpu_stall=1; 10th cycle CPU owner again with starve_cnt=0.
4. dma_lock=1 for 5 cycles with cpu_req=1 to RAM address -> first cycle CPU served; following 5 cycles cpu_stall=1 and DMA owns RAM; stall drops the cycle after dma_lock is sampled 0.
5. CPU access to 0xFF00_0004 with dma_req=1 in CPU_PRI -> io_sel=1, dma_gnt=1, cpu_stall=0, ram_we=dma_we.
6. Assert clrn=0 during LOCK with a DMA read granted -> dma_rvalid=0, dma_rdata=0, state CPU_PRI. After release, CPU access is served without stall.
